pause_ctl: RTL and testbench
============================

# pause_ctl

Frame-aligned, multi-source pause controller for arcade cores. It merges N pause requests, the user button and the OSD state. Pause entry is aligned to the vblank rising edge, so the CPU halts at a frame boundary. While paused, it can advance a single frame and fades the RGB output in progressive right-shift steps to limit burn-in. It sits between the HPS/OSD glue and the CPU clock-enable and arcade_video path.

## Interface
- RW, 8, red channel width
- GW, 8, green channel width
- BW, 8, blue channel width
- CLKSPD, 48, clk_sys frequency in MHz
- NREQ, 2, number of pause_request sources (≥1)
- DIM_SECS, 10, seconds paused before fading starts
- DIM_MAX, 2, maximum right-shift applied to each channel (1..3)
- FADE_FRAMES, 8, vblank edges between successive dim steps
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- user_button  in  1  pause toggle button, active-high
- step_button  in  1  frame-advance button, active-high
- pause_request  in  NREQ  pause requests from other logic (hiscore etc.), active-high
- options  in  2  [0] pause in OSD, [1] dim enable
- OSD_STATUS  in  1  OSD open
- vblank  in  1  video vertical blank, clk_sys domain
- r / g / b  in  RW / GW / BW  video channels
- pause_cpu  out  1  CPU halt, registered
- paused  out  1  high only in state PAUSED
- dim_level  out  2  current shift, 0..DIM_MAX
- rgb_out  out  RW+GW+BW  {r>>dim_level, g>>dim_level, b>>dim_level}

## Operation
- Rising-edge detectors on user_button, step_button and vblank use registered previous values.
- vbl_edge = vblank & ~vblank_q.
- toggle flips on each user_button edge.
- want = |pause_request | toggle | (OSD_STATUS & options[0]).
- States: RUN, PEND, PAUSED, STEP.
  - RUN: pause_cpu=0. want → PEND.
  - PEND: pause_cpu=0.
    - ~want → RUN (this has priority).
    - vbl_edge → PAUSED.
    - Watchdog reaches CLKSPD*100000 cycles (100 ms, no video) → PAUSED.
  - PAUSED: pause_cpu=1.
    - ~want → RUN; resume is immediate, not frame-aligned.
    - step edge → STEP (only when the macro is defined).
  - STEP: pause_cpu=0.
    - vbl_edge → PAUSED if want, else RUN.
    - Further step edges are ignored.
    - The watchdog also applies here.
- Dim:
  - A 32-bit timer counts while in PAUSED with options[1]=1.
  - At DIM_SECS*CLKSPD*1e6 the timer saturates, and dim_level increments once every FADE_FRAMES vbl_edges, up to DIM_MAX.
  - Leaving PAUSED, options[1]=0, or entering STEP clears the timer, frame counter and dim_level in the next cycle.
- rgb_out is combinational from the registered dim_level.
- Reset:
  - State RUN; pause_cpu, paused, toggle, dim_level and all counters cleared.
  - Button edges are ignored during reset.
  - If reset occurs mid-PAUSED, pause_cpu is 0 after the reset edge.
  - If want is still high after reset releases, the block re-enters PEND.

## Timing
- The state register and pause_cpu update on the same edge.
- With vbl_edge true in PEND at cycle k, pause_cpu=1 and paused=1 from cycle k+1.
- want falling in PAUSED at cycle k gives pause_cpu=0 from k+1.
- Input-to-edge latency:
  - vblank and buttons: 1 cycle (detector register).
  - want: combinational.
- Simultaneous events:
  - In PEND, ~want together with vbl_edge → RUN.
  - In PAUSED, ~want together with a step edge → RUN.
- Dim steps occur exactly on vbl_edge cycles. With vblank stuck low the fade stalls at its current level.

## Configuration
- PAUSE_FRAME_STEP_EN
  - Defined: the STEP state and step_button are active.
  - Undefined: step_button is ignored; the STEP state and its logic are not synthesised; PAUSED exits only on ~want.

## Structure
- Package pause_pkg holds:
  - the state enum (RUN, PEND, PAUSED, STEP),
  - option index constants OPT_PAUSE_OSD=0 and OPT_DIM=1,
  - functions computing the dim timeout and the watchdog limit from CLKSPD and DIM_SECS.
- Sub-module pause_dim holds the timer, frame counter and dim_level. Its inputs are active, vbl_edge and clear.

## Test plan
Tests use CLKSPD=1, DIM_SECS=1, FADE_FRAMES=2, DIM_MAX=2, and vblank period 1000 cycles.
- pause_request[1]=1 at cycle 10, vblank rises at 500 → pause_cpu=0 until 500, then 1 at 501.
- user_button pulse while paused → toggle=0, pause_cpu=0 one cycle after the detected edge. Second pulse → re-pause at the next vblank edge.
- Paused with options[1]=1 → dim_level 0 until 1e6 cycles, then 1 after 2 vbl_edges, 2 after 4, holds at 2. rgb_out for r=0xFF is 0x3F.
- Step edge while paused (macro defined) → pause_cpu=0 for exactly one frame, then paused=1 and dim_level=0.
- vblank held low, pause requested → PAUSED after 100000 cycles.
- Reset asserted in PAUSED with toggle=1 → pause_cpu=0, dim_level=0 after one edge; toggle stays 0 after release.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared types and constants for the frame-aligned pause controller.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN,
        PEND,
        PAUSED,
        STEP
    } pause_state_t;

    localparam int OPT_PAUSE_OSD = 0;
    localparam int OPT_DIM       = 1;

    // Cycles paused before the fade may start (DIM_SECS seconds at CLKSPD MHz).
    function automatic logic [31:0] dim_timeout(input int clkspd, input int dim_secs);
        longint cycles;
        cycles = longint'(clkspd) * longint'(dim_secs) * longint'(1000000);
        return 32'(cycles);
    endfunction

    // Cycles to wait for a vblank edge before pausing anyway (100 ms).
    function automatic logic [31:0] watchdog_limit(input int clkspd);
        return 32'(clkspd * 100000);
    endfunction

endpackage

// File: rtl/pause_dim.sv
// Burn-in fade: waits for the dim timeout while paused, then raises the
// right-shift applied to the video by one step every FADE_FRAMES vblank edges.
module pause_dim
    import pause_pkg::*;
#(
    parameter int CLKSPD      = 48,
    parameter int DIM_SECS    = 10,
    parameter int DIM_MAX     = 2,
    parameter int FADE_FRAMES = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       active,
    input  logic       vbl_edge,
    input  logic       clear,
    output logic [1:0] dim_level
);

    localparam logic [31:0] TIMEOUT = dim_timeout(CLKSPD, DIM_SECS);
    localparam int          FW      = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FW-1:0] LAST  = FW'(FADE_FRAMES - 1);

    logic [31:0]   timer;
    logic [FW-1:0] frame_cnt;

    // Timer saturates at the timeout; only then are vblank edges counted toward dim steps.
    always_ff @(posedge clk_sys) begin
        // NOTE: all state in clocked blocks uses <= so every register samples
        // pre-edge values, independent of statement order.
        if (reset || clear) begin
            timer     <= '0;
            frame_cnt <= '0;
            dim_level <= '0;
        end else if (active) begin
            if (timer != TIMEOUT) begin
                timer <= timer + 32'd1;
            end else if (vbl_edge) begin
                if (frame_cnt == LAST) begin
                    frame_cnt <= '0;
                    if (dim_level < 2'(DIM_MAX)) begin
                        dim_level <= dim_level + 2'd1;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pause_ctl.sv
// Frame-aligned multi-source pause controller. Merges pause requests, the
// user toggle button and the OSD, halts the CPU on a vblank rising edge and
// fades the video while paused. Build option PAUSE_FRAME_STEP_EN enables the
// single-frame advance (STEP state, step_button).
module pause_ctl
    import pause_pkg::*;
#(
    parameter int RW          = 8,
    parameter int GW          = 8,
    parameter int BW          = 8,
    parameter int CLKSPD      = 48,
    parameter int NREQ        = 2,
    parameter int DIM_SECS    = 10,
    parameter int DIM_MAX     = 2,
    parameter int FADE_FRAMES = 8
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic                  step_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic [1:0]            options,
    input  logic                  OSD_STATUS,
    input  logic                  vblank,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic                  pause_cpu,
    output logic                  paused,
    output logic [1:0]            dim_level,
    output logic [RW+GW+BW-1:0]   rgb_out
);

    localparam logic [31:0] WD_LIMIT = watchdog_limit(CLKSPD);

    pause_state_t state, state_next;
    logic         user_q, vblank_q, toggle;
    logic         user_edge, vbl_edge, want;
    logic         wd_counting, wd_done, dim_active;
    logic [31:0]  wd_cnt;

    assign user_edge = user_button & ~user_q;
    assign vbl_edge  = vblank & ~vblank_q;
    assign want      = (|pause_request) | toggle | (OSD_STATUS & options[OPT_PAUSE_OSD]);

`ifdef PAUSE_FRAME_STEP_EN
    logic step_q, step_edge;
    assign step_edge = step_button & ~step_q;

    // Step-button edge detector; tracks the pin during reset like the others.
    always_ff @(posedge clk_sys) begin
        step_q <= step_button;
    end

    assign wd_counting = (state == PEND) || (state == STEP);
`else
    logic unused_step;
    assign unused_step = step_button;
    assign wd_counting = (state == PEND);
`endif

    assign wd_done = wd_counting && (wd_cnt == WD_LIMIT - 32'd1);

    // Edge detectors and the user toggle.
    always_ff @(posedge clk_sys) begin
        user_q   <= user_button;
        vblank_q <= vblank;
        // NOTE: the previous-value registers keep following the pins during
        // reset, so a button held across reset release is not seen as an edge.
        if (reset) begin
            toggle <= 1'b0;
        end else begin
            toggle <= toggle ^ user_edge;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            RUN: begin
                if (want) state_next = PEND;
            end
            PEND: begin
                if (!want)                    state_next = RUN;
                else if (vbl_edge || wd_done) state_next = PAUSED;
            end
            PAUSED: begin
                if (!want) state_next = RUN;
`ifdef PAUSE_FRAME_STEP_EN
                else if (step_edge) state_next = STEP;
`endif
            end
`ifdef PAUSE_FRAME_STEP_EN
            STEP: begin
                if (vbl_edge || wd_done) state_next = want ? PAUSED : RUN;
            end
`endif
            default: state_next = RUN;
        endcase
    end

    // State register, registered CPU halt and the missing-video watchdog.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= RUN;
            pause_cpu <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            state     <= state_next;
            pause_cpu <= (state_next == PAUSED);
            wd_cnt    <= (wd_counting && state_next == state) ? wd_cnt + 32'd1 : '0;
        end
    end

    assign paused     = (state == PAUSED);
    assign dim_active = paused & options[OPT_DIM];

    pause_dim #(
        .CLKSPD      (CLKSPD),
        .DIM_SECS    (DIM_SECS),
        .DIM_MAX     (DIM_MAX),
        .FADE_FRAMES (FADE_FRAMES)
    ) u_dim (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .active    (dim_active),
        .vbl_edge  (vbl_edge),
        .clear     (~dim_active),
        .dim_level (dim_level)
    );

    assign rgb_out = {r >> dim_level, g >> dim_level, b >> dim_level};

endmodule

// File: tb/tb_pause_ctl.sv
// Self-checking bench for pause_ctl: directed vector table, multi-cycle
// corner sequences, and a randomized run against a frame-level model.
module tb_pause_ctl;

    localparam int RW = 8, GW = 8, BW = 8;
    localparam int CLKSPD = 1, NREQ = 2, DIM_SECS = 1, DIM_MAX = 2, FADE_FRAMES = 2;
    localparam int DIM_CYCLES = DIM_SECS * CLKSPD * 1000000;
    localparam int WD_CYCLES  = CLKSPD * 100000;

`ifdef PAUSE_FRAME_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic            clk_sys = 1'b0;
    logic            reset = 1'b1;
    logic            user_button = 1'b0;
    logic            step_button = 1'b0;
    logic [NREQ-1:0] pause_request = '0;
    logic [1:0]      options = '0;
    logic            OSD_STATUS = 1'b0;
    logic            vblank = 1'b0;
    logic [RW-1:0]   r = '0;
    logic [GW-1:0]   g = '0;
    logic [BW-1:0]   b = '0;
    logic            pause_cpu, paused;
    logic [1:0]      dim_level;
    logic [RW+GW+BW-1:0] rgb_out;

    int total = 0;
    int bad   = 0;

    pause_ctl #(
        .RW(RW), .GW(GW), .BW(BW), .CLKSPD(CLKSPD), .NREQ(NREQ),
        .DIM_SECS(DIM_SECS), .DIM_MAX(DIM_MAX), .FADE_FRAMES(FADE_FRAMES)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
        .step_button(step_button), .pause_request(pause_request),
        .options(options), .OSD_STATUS(OSD_STATUS), .vblank(vblank),
        .r(r), .g(g), .b(b), .pause_cpu(pause_cpu), .paused(paused),
        .dim_level(dim_level), .rgb_out(rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0] req;
        logic       ub;
        logic       vbl;
        logic       osd;
        logic       opt0;
        logic       exp_pc;
    } vec_t;

    vec_t tbl[25];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic vbl_pulse();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
    endtask

    task automatic ub_pulse();
        user_button = 1'b1;
        tick();
        user_button = 1'b0;
        tick();
    endtask

    // Frame-level reference model state
    localparam int M_RUN = 0, M_WAIT_FRAME = 1, M_HALTED = 2, M_ADVANCE = 3;
    int m_mode, m_wait;
    bit m_tog, m_ubq, m_sbq, m_vbq;

    initial begin
        tbl[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        check("reset_pause_cpu", 32'(pause_cpu), 32'd0);
        check("reset_paused", 32'(paused), 32'd0);
        check("reset_dim", 32'(dim_level), 32'd0);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 25; i++) begin
            pause_request = tbl[i].req;
            user_button   = tbl[i].ub;
            vblank        = tbl[i].vbl;
            OSD_STATUS    = tbl[i].osd;
            options       = {1'b0, tbl[i].opt0};
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            tick();
            check($sformatf("vec%0d_pause_cpu", i), 32'(pause_cpu), 32'(tbl[i].exp_pc));
            check($sformatf("vec%0d_paused", i), 32'(paused), 32'(tbl[i].exp_pc));
            check($sformatf("vec%0d_rgb", i), 32'(rgb_out), {8'h0, r, g, b});
        end
        options = '0;

        // Request at cycle 10, vblank rising at cycle 500
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            pause_request = (c >= 10) ? 2'b10 : 2'b00;
            vblank = (c >= 500);
            tick();
            if (c == 10)  check("align_pend", 32'(pause_cpu), 32'd0);
            if (c == 499) check("align_before_vbl", 32'(pause_cpu), 32'd0);
            if (c == 500) check("align_at_vbl", 32'(pause_cpu), 32'd1);
            if (c == 500) check("align_paused", 32'(paused), 32'd1);
        end
        pause_request = '0;
        tick();
        check("req_drop_resume", 32'(pause_cpu), 32'd0);

        // User toggle: pause, resume, re-pause on next vblank edge
        vblank = 1'b0;
        ub_pulse();
        check("toggle_pend", 32'(pause_cpu), 32'd0);
        vblank = 1'b1;
        tick();
        check("toggle_paused", 32'(pause_cpu), 32'd1);
        ub_pulse();
        check("toggle_resume", 32'(pause_cpu), 32'd0);
        ub_pulse();
        check("toggle_wait_frame", 32'(pause_cpu), 32'd0);
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        check("toggle_repause", 32'(pause_cpu), 32'd1);
        vblank = 1'b0;

        // Dim: timeout with vblank stuck low, then steps on vblank edges
        options = 2'b10;
        r = 8'hFF; g = 8'h80; b = 8'h01;
        for (int i = 0; i < DIM_CYCLES + 20; i++) begin
            tick();
            if (i == DIM_CYCLES - 20) check("dim_before_timeout", 32'(dim_level), 32'd0);
        end
        check("dim_stall_no_vbl", 32'(dim_level), 32'd0);
        vbl_pulse();
        check("dim_edge1", 32'(dim_level), 32'd0);
        vbl_pulse();
        check("dim_edge2", 32'(dim_level), 32'd1);
        check("rgb_dim1", 32'(rgb_out), 32'h7F4000);
        vbl_pulse();
        check("dim_edge3", 32'(dim_level), 32'd1);
        vbl_pulse();
        check("dim_edge4", 32'(dim_level), 32'd2);
        check("rgb_dim2", 32'(rgb_out), 32'h3F2000);
        vbl_pulse();
        vbl_pulse();
        check("dim_hold_max", 32'(dim_level), 32'd2);
        check("dim_still_paused", 32'(pause_cpu), 32'd1);

`ifdef PAUSE_FRAME_STEP_EN
        // Frame step: CPU runs until the next vblank edge, second press ignored
        begin
            int zeros;
            step_button = 1'b1;
            tick();
            check("step_run", 32'(pause_cpu), 32'd0);
            zeros = (pause_cpu == 1'b0) ? 1 : 0;
            for (int i = 0; i < 300; i++) begin
                step_button = (i == 100);
                tick();
                if (pause_cpu == 1'b0) zeros++;
            end
            check("step_dim_cleared", 32'(dim_level), 32'd0);
            vblank = 1'b1;
            tick();
            vblank = 1'b0;
            check("step_repaused", 32'(pause_cpu), 32'd1);
            check("step_paused_flag", 32'(paused), 32'd1);
            check("step_frame_len", 32'(zeros), 32'd301);
            check("step_dim_after", 32'(dim_level), 32'd0);
        end
`else
        step_button = 1'b1;
        tick();
        step_button = 1'b0;
        tick();
        vbl_pulse();
        check("step_ignored_pc", 32'(pause_cpu), 32'd1);
        check("step_ignored_dim", 32'(dim_level), 32'd2);
`endif
        options = 2'b00;
        tick();
        check("dim_opt_clear", 32'(dim_level), 32'd0);

        // ~want together with a step edge in PAUSED resumes
        pause_request = 2'b01;
        ub_pulse();
        check("req_holds_pause", 32'(pause_cpu), 32'd1);
        pause_request = 2'b00;
        step_button = 1'b1;
        tick();
        step_button = 1'b0;
        check("unwant_step_resume", 32'(pause_cpu), 32'd0);
        vbl_pulse();
        check("unwant_step_stay_run", 32'(pause_cpu), 32'd0);

        // Watchdog with no video
        vblank = 1'b0;
        pause_request = 2'b01;
        for (int i = 0; i <= WD_CYCLES + 5; i++) begin
            tick();
            if (i == WD_CYCLES - 2) check("wd_before", 32'(pause_cpu), 32'd0);
            if (i == WD_CYCLES + 1) check("wd_after", 32'(pause_cpu), 32'd1);
        end
        pause_request = 2'b00;
        tick();

        // Reset while paused by toggle, button held across reset
        ub_pulse();
        vbl_pulse();
        check("pre_reset_paused", 32'(pause_cpu), 32'd1);
        reset = 1'b1;
        user_button = 1'b1;
        tick();
        check("reset_mid_pc", 32'(pause_cpu), 32'd0);
        check("reset_mid_paused", 32'(paused), 32'd0);
        check("reset_mid_dim", 32'(dim_level), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        user_button = 1'b0;
        tick();
        vbl_pulse();
        check("toggle_cleared_by_reset", 32'(pause_cpu), 32'd0);
        pause_request = 2'b01;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("reenter_pend", 32'(pause_cpu), 32'd0);
        vbl_pulse();
        check("reenter_pause", 32'(pause_cpu), 32'd1);

        // Randomized run against the frame-level model
        pause_request = '0; user_button = 0; step_button = 0; vblank = 0;
        OSD_STATUS = 0; options = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_mode = M_RUN; m_wait = 0; m_tog = 0; m_ubq = 0; m_sbq = 0; m_vbq = 0;
        for (int n = 0; n < 4000; n++) begin
            bit ue, se, ve, want, wd_hit, waiting;
            int nxt;
            if ($urandom_range(15) == 0) pause_request = 2'($urandom);
            if ($urandom_range(31) == 0) OSD_STATUS = ~OSD_STATUS;
            if ($urandom_range(31) == 0) options = 2'($urandom);
            if ($urandom_range(19) == 0) vblank = ~vblank;
            user_button = ($urandom_range(11) == 0);
            step_button = ($urandom_range(7) == 0);
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);

            ue = user_button & ~m_ubq;
            se = step_button & ~m_sbq;
            ve = vblank & ~m_vbq;
            want = (|pause_request) | m_tog | (OSD_STATUS & options[0]);
            wd_hit = (m_wait == WD_CYCLES - 1);
            nxt = m_mode;
            case (m_mode)
                M_RUN:        if (want) nxt = M_WAIT_FRAME;
                M_WAIT_FRAME: if (!want) nxt = M_RUN; else if (ve || wd_hit) nxt = M_HALTED;
                M_HALTED:     if (!want) nxt = M_RUN; else if (STEP_EN && se) nxt = M_ADVANCE;
                default:      if (ve || wd_hit) nxt = want ? M_HALTED : M_RUN;
            endcase
            waiting = (m_mode == M_WAIT_FRAME) || (m_mode == M_ADVANCE);
            m_wait = (waiting && nxt == m_mode) ? m_wait + 1 : 0;
            m_mode = nxt;
            m_tog = m_tog ^ ue;
            m_ubq = user_button; m_sbq = step_button; m_vbq = vblank;

            tick();
            check($sformatf("rnd%0d_pause_cpu", n), 32'(pause_cpu), 32'(m_mode == M_HALTED));
            check($sformatf("rnd%0d_paused", n), 32'(paused), 32'(m_mode == M_HALTED));
            check($sformatf("rnd%0d_rgb", n), 32'(rgb_out), {8'h0, r, g, b});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
